lights_pll_supervisor: RTL and testbench



---
 rtl/lights_pll_sup_pkg.sv | 24 ++
 rtl/lights_sync2.sv | 23 ++
 rtl/lights_pll_supervisor.sv | 140 ++++++++++++++
 tb/tb_lights_pll_supervisor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lights_pll_sup_pkg.sv
// Shared types and helpers for the lights PLL supervisor.
// The optional lock-loss counter is enabled by LIGHTS_PLL_SUP_LOSS_CNT_EN.
package lights_pll_sup_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    localparam int LOSS_CNT_W = 8;

    // Width of a counter that must reach (largest period - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lights_sync2.sv
// Generic two-flop synchronizer; asynchronous active-low reset clears both stages.
module lights_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lights_pll_supervisor.sv
// Sequences the PLL reset, qualifies lock and gates the system reset; retries on lock timeout.
// Define LIGHTS_PLL_SUP_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module lights_pll_supervisor
    import lights_pll_sup_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               sw_restart,
    output logic                               pll_rst,
    output logic                               sys_rst_n,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
`ifdef LIGHTS_PLL_SUP_LOSS_CNT_EN
    output logic [LOSS_CNT_W-1:0]              lock_loss_cnt,
`endif
    output sup_state_t                         state_dbg
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W   = cnt_width(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    sup_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [RETRY_W-1:0] retry_next;
    logic               locked_s;

    lights_sync2 #(.WIDTH(1)) u_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            cnt         <= '0;
            retry_count <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            retry_count <= retry_next;
        end
    end

    // Every path that changes state also clears the shared counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        retry_next = retry_count;
        if (sw_restart) begin
            state_next = HOLD;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_next = retry_count + RETRY_W'(1);
                        state_next = (retry_next == RETRY_LIMIT) ? FAULT : HOLD;
                        cnt_next   = '0;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                        retry_next = '0;
                    end
                end
                RUN: begin
                    cnt_next = '0;
                    if (!locked_s) state_next = HOLD;
                end
                FAULT: begin
                    cnt_next = '0;
                end
                default: begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            pll_rst   <= (state_next == HOLD) || (state_next == FAULT);
            sys_rst_n <= (state_next == RUN);
            ready     <= (state_next == RUN);
            fault     <= (state_next == FAULT);
        end
    end

    assign state_dbg = state;

`ifdef LIGHTS_PLL_SUP_LOSS_CNT_EN
    logic run_loss;
    assign run_loss = (state == RUN) && !locked_s && !sw_restart;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (run_loss && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_lights_pll_supervisor.sv
// Directed and randomized checks of lights_pll_supervisor against a cycle-level behavioural model.
// Define LIGHTS_PLL_SUP_LOSS_CNT_EN to also check lock_loss_cnt.
module tb_lights_pll_supervisor;
    import lights_pll_sup_pkg::*;

    localparam int RST_HOLD = 4;
    localparam int STABLE_N = 8;
    localparam int TIMEOUT  = 32;
    localparam int MAX_RET  = 2;
    localparam int RW       = $clog2(MAX_RET + 1);

    localparam int M_HOLD = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAULT = 4;

    logic          refclk;
    logic          rst_n;
    logic          pll_locked;
    logic          sw_restart;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry_count;
    sup_state_t    state_dbg;
`ifdef LIGHTS_PLL_SUP_LOSS_CNT_EN
    logic [7:0]    lock_loss_cnt;
`endif

    int n_tests  = 0;
    int n_failed = 0;

    // Behavioural model: phase, cycles spent in phase, retries, losses, 2-deep delay line.
    int   m_phase;
    int   m_elapsed;
    int   m_retries;
    int   m_losses;
    logic m_sync_q[$];

    lights_pll_supervisor #(
        .RST_HOLD_CYCLES     (RST_HOLD),
        .LOCK_STABLE_CYCLES  (STABLE_N),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (MAX_RET)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .sw_restart    (sw_restart),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .retry_count   (retry_count),
`ifdef LIGHTS_PLL_SUP_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .state_dbg     (state_dbg)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = M_HOLD;
        m_elapsed = 0;
        m_retries = 0;
        m_losses  = 0;
        m_sync_q  = '{1'b0, 1'b0};
    endtask

    task automatic model_step(input logic lk, input logic rs);
        logic ls;
        ls = m_sync_q.pop_front();
        m_sync_q.push_back(lk);
        if (rs) begin
            m_phase   = M_HOLD;
            m_elapsed = 0;
            m_retries = 0;
        end else begin
            case (m_phase)
                M_HOLD: begin
                    m_elapsed++;
                    if (m_elapsed == RST_HOLD) begin
                        m_phase   = M_WAIT;
                        m_elapsed = 0;
                    end
                end
                M_WAIT: begin
                    if (ls) begin
                        m_phase   = M_STABLE;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == TIMEOUT) begin
                            m_retries++;
                            m_phase   = (m_retries == MAX_RET) ? M_FAULT : M_HOLD;
                            m_elapsed = 0;
                        end
                    end
                end
                M_STABLE: begin
                    if (!ls) begin
                        m_phase   = M_WAIT;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == STABLE_N) begin
                            m_phase   = M_RUN;
                            m_elapsed = 0;
                            m_retries = 0;
                        end
                    end
                end
                M_RUN: begin
                    if (!ls) begin
                        m_phase = M_HOLD;
                        if (m_losses < 255) m_losses++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("pll_rst", 32'(pll_rst), 32'((m_phase == M_HOLD) || (m_phase == M_FAULT)));
        chk("sys_rst_n", 32'(sys_rst_n), 32'(m_phase == M_RUN));
        chk("ready", 32'(ready), 32'(m_phase == M_RUN));
        chk("fault", 32'(fault), 32'(m_phase == M_FAULT));
        chk("retry_count", 32'(retry_count), 32'(m_retries));
`ifdef LIGHTS_PLL_SUP_LOSS_CNT_EN
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_losses));
`endif
    endtask

    task automatic cycle(input logic lk, input logic rs);
        pll_locked = lk;
        sw_restart = rs;
        @(posedge refclk);
        model_step(lk, rs);
        #1;
        check_outputs();
    endtask

    task automatic cycles(input int n, input logic lk);
        for (int i = 0; i < n; i++) cycle(lk, 1'b0);
    endtask

    initial begin
        int   len;
        logic lk;
        logic rs;

        // Reset state
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        sw_restart = 1'b0;
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Nominal bring-up: lock appears at cycle 10
        cycles(10, 1'b0);
        cycles(20, 1'b1);
        chk("nominal_ready", 32'(ready), 32'd1);

        // Repeated loss of lock in RUN, re-lock each time
        for (int i = 0; i < 260; i++) begin
            cycles($urandom_range(1, 3), 1'b0);
            cycles(22, 1'b1);
        end
`ifdef LIGHTS_PLL_SUP_LOSS_CNT_EN
        chk("loss_saturated", 32'(lock_loss_cnt), 32'd255);
`endif

        // Lock never comes: two timeouts then FAULT, which persists
        cycles(100, 1'b0);
        chk("fault_reached", 32'(fault), 32'd1);
        cycles(10, 1'b1);
        cycle(1'b0, 1'b1);
        chk("restart_clears_fault", 32'(fault), 32'd0);

        // One timeout, then a lock glitch in STABLE; retry_count must hold at 1
        cycles(RST_HOLD + TIMEOUT + RST_HOLD, 1'b0);
        chk("one_retry", 32'(retry_count), 32'd1);
        cycles(5, 1'b1);
        cycles(1, 1'b0);
        cycles(20, 1'b1);

        // sw_restart on the very edge a timeout would fire
        cycle(1'b0, 1'b1);
        cycles(RST_HOLD + TIMEOUT - 1, 1'b0);
        cycle(1'b0, 1'b1);
        chk("restart_beats_timeout", 32'(retry_count), 32'd0);

        // Asynchronous reset mid-STABLE
        cycles(10, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge refclk);
        #1;
        rst_n = 1'b1;

        // Randomized lock activity with occasional restarts
        for (int i = 0; i < 80; i++) begin
            len = $urandom_range(1, 40);
            lk  = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                rs = ($urandom_range(0, 63) == 0);
                cycle(lk, rs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
